sprite_scaler_renderer: RTL and testbench

- Parametrised successor to the full-screen sprite stretcher.
- Renders one SPR_W x SPR_H palette-indexed sprite at a programmable screen position, with integer scale factor, horizontal flip and transparency key.
- Generates ROM addresses with counters, not multiply/divide, and drives an external synchronous sprite ROM.
- Emits a pipelined palette index plus hit flag for the downstream layer compositor / palette stage.

---
 rtl/sprite_pkg.sv | 8 +
 rtl/sprite_scaler_renderer_if.sv | 11 +
 rtl/sprite_axis_counter.sv | 61 ++++++
 rtl/sprite_scaler_renderer.sv | 118 +++++++++++
 tb/tb_sprite_scaler_renderer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared screen constants and coordinate type for the sprite renderer.
package sprite_pkg;
    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;
    localparam int TRANSP_IDX_DEF = 0;

    typedef logic [9:0] coord_t;
endpackage

// File: rtl/sprite_scaler_renderer_if.sv
// Sprite ROM bus: registered address out, synchronous data back one cycle later.
interface sprite_rom_if #(
    parameter int ADDR_W = 10,
    parameter int IDX_W  = 8
);
    logic [ADDR_W-1:0] rom_address;
    logic [IDX_W-1:0]  rom_q;

    modport master (output rom_address, input rom_q);
    modport slave  (input rom_address, output rom_q);
endinterface

// File: rtl/sprite_axis_counter.sv
// One screen axis of the sprite box: range test plus scaled texel counter
// (sub-counter wraps at scale-1, main counter saturates at N-1).
module sprite_axis_counter
    import sprite_pkg::*;
#(
    parameter int N       = 32,
    parameter int SCALE_W = 3
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    input  coord_t               coord_i,
    input  coord_t               pos_i,
    input  logic [SCALE_W-1:0]   scale_i,
    input  logic                 upd_i,
    input  logic                 adv_i,
    output logic                 in_range_o,
    output logic [$clog2(N)-1:0] idx_o
);
    localparam int              CW    = $clog2(N);
    localparam int              EXT_W = 11 + SCALE_W + CW;
    localparam logic [CW-1:0]   MAXV  = CW'(N - 1);

    logic [CW-1:0]      main_q, main_d;
    logic [SCALE_W-1:0] sub_q, sub_d;
    logic [EXT_W-1:0]   lo, hi, cur;

    // N is a power of two, so the box extent is a plain shift of the scale.
    assign lo         = EXT_W'(pos_i);
    assign hi         = lo + (EXT_W'(scale_i) << CW);
    assign cur        = EXT_W'(coord_i);
    assign in_range_o = (cur >= lo) && (cur < hi);

    always_comb begin
        main_d = main_q;
        sub_d  = sub_q;
        if (upd_i && coord_i == pos_i) begin
            main_d = '0;
            sub_d  = '0;
        end else if (upd_i && adv_i) begin
            if (sub_q >= scale_i - SCALE_W'(1)) begin
                sub_d = '0;
                if (main_q != MAXV) main_d = main_q + 1'b1;
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    // Index for the pixel presented this cycle, not the stored one.
    assign idx_o = main_d;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q <= '0;
            sub_q  <= '0;
        end else begin
            main_q <= main_d;
            sub_q  <= sub_d;
        end
    end
endmodule

// File: rtl/sprite_scaler_renderer.sv
// Scaled/flipped sprite renderer: per-frame shadowed placement, counter-based
// ROM addressing and a fixed 3-cycle palette-index pipeline.
module sprite_scaler_renderer
    import sprite_pkg::*;
#(
    parameter int          SPR_W      = 32,
    parameter int          SPR_H      = 32,
    parameter int          IDX_W      = 8,
    parameter int          SCALE_W    = 3,
    parameter int unsigned TRANSP_IDX = TRANSP_IDX_DEF,
    parameter int          ADDR_W     = $clog2(SPR_W * SPR_H)
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  coord_t             DrawX,
    input  coord_t             DrawY,
    input  logic               blank,
    input  logic               enable,
    input  coord_t             pos_x,
    input  coord_t             pos_y,
    input  logic [SCALE_W-1:0] scale,
    input  logic               flip_x,
    sprite_rom_if.master       rom,
    output logic [IDX_W-1:0]   pix_index,
    output logic               pix_hit
);
    localparam int               XW       = $clog2(SPR_W);
    localparam int               YW       = $clog2(SPR_H);
    localparam logic [IDX_W-1:0] TRANSP_V = IDX_W'(TRANSP_IDX);

    logic               frame_start, line_start;
    coord_t             pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [SCALE_W-1:0] scale_q, scale_d;
    logic               flip_q, flip_d, en_q, en_d;
    logic               in_x, in_y, prev_in_y_q, v1;
    logic [XW-1:0]      col, tx;
    logic [YW-1:0]      row;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [1:0]         vld_pipe_q;
    logic [IDX_W-1:0]   pix_index_q;
    logic               pix_hit_q;

    assign frame_start = (DrawX == '0) && (DrawY == '0);
    assign line_start  = (DrawX == '0);

    // On the frame-start cycle the live inputs are used directly, so pixel
    // (0,0) already belongs to the newly latched frame.
    assign pos_x_d = frame_start ? pos_x : pos_x_q;
    assign pos_y_d = frame_start ? pos_y : pos_y_q;
    assign scale_d = !frame_start ? scale_q : (scale == '0) ? SCALE_W'(1) : scale;
    assign flip_d  = frame_start ? flip_x : flip_q;
    assign en_d    = frame_start ? enable : en_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
            scale_q <= SCALE_W'(1);
            flip_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            scale_q <= scale_d;
            flip_q  <= flip_d;
            en_q    <= en_d;
        end
    end

    sprite_axis_counter #(.N(SPR_W), .SCALE_W(SCALE_W)) u_x (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .coord_i    (DrawX),
        .pos_i      (pos_x_d),
        .scale_i    (scale_d),
        .upd_i      (1'b1),
        .adv_i      (in_x),
        .in_range_o (in_x),
        .idx_o      (col)
    );

    // Rows step once per line, and only if the line just finished was inside the box.
    sprite_axis_counter #(.N(SPR_H), .SCALE_W(SCALE_W)) u_y (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .coord_i    (DrawY),
        .pos_i      (pos_y_d),
        .scale_i    (scale_d),
        .upd_i      (line_start),
        .adv_i      (prev_in_y_q),
        .in_range_o (in_y),
        .idx_o      (row)
    );

    assign tx         = flip_d ? ~col : col;
    assign v1         = blank && en_d && in_x && in_y;
    assign rom_addr_d = v1 ? {row, tx} : rom_addr_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_in_y_q <= 1'b0;
            rom_addr_q  <= '0;
            vld_pipe_q  <= '0;
            pix_index_q <= '0;
            pix_hit_q   <= 1'b0;
        end else begin
            if (line_start) prev_in_y_q <= in_y;
            rom_addr_q  <= rom_addr_d;
            vld_pipe_q  <= {vld_pipe_q[0], v1};
            pix_index_q <= rom.rom_q;
            pix_hit_q   <= vld_pipe_q[1] && (rom.rom_q != TRANSP_V);
        end
    end

    assign rom.rom_address = rom_addr_q;
    assign pix_index       = pix_index_q;
    assign pix_hit         = pix_hit_q;
endmodule

// File: tb/tb_sprite_scaler_renderer.sv
// Bench for sprite_scaler_renderer: scanned pixels against an arithmetic
// (division-based) placement model with a synchronous ROM model.
module tb_sprite_scaler_renderer;
    import sprite_pkg::*;

    localparam int SW  = 32;
    localparam int SH  = 32;
    localparam int IW  = 8;
    localparam int SCW = 3;
    localparam int AW  = 10;

    logic           vga_clk = 1'b0;
    logic           reset_n = 1'b0;
    coord_t         DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
    logic           blank = 1'b0, enable = 1'b0, flip_x = 1'b0;
    logic [SCW-1:0] scale = 3'd1;
    logic [IW-1:0]  pix_index;
    logic           pix_hit;
    logic [IW-1:0]  rom_mem [0:SW*SH-1];

    sprite_rom_if #(.ADDR_W(AW), .IDX_W(IW)) rif ();

    sprite_scaler_renderer dut (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .blank     (blank),
        .enable    (enable),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .scale     (scale),
        .flip_x    (flip_x),
        .rom       (rif),
        .pix_index (pix_index),
        .pix_hit   (pix_hit)
    );

    always #5 vga_clk = ~vga_clk;
    always @(posedge vga_clk) rif.rom_q <= rom_mem[rif.rom_address];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: frame parameters, held address, output history.
    int fr_px, fr_py, fr_s, e_addr;
    bit fr_flip, fr_en;
    bit h_hit [3];
    int h_idx [3];

    task automatic model_reset();
        fr_px = 0; fr_py = 0; fr_s = 1; fr_flip = 0; fr_en = 0; e_addr = 0;
        for (int i = 0; i < 3; i++) begin h_hit[i] = 0; h_idx[i] = 0; end
    endtask

    // Present one pixel for one clock; afterwards e_addr is the expected
    // rom_address and h_hit[2]/h_idx[2] the expected pixel output.
    task automatic step(input int x, input int y, input bit b);
        int col, row, a;
        bit v;
        DrawX = coord_t'(x); DrawY = coord_t'(y); blank = b;
        if (x == 0 && y == 0) begin
            fr_px = int'(pos_x); fr_py = int'(pos_y);
            fr_s = (scale == 0) ? 1 : int'(scale);
            fr_flip = flip_x; fr_en = enable;
        end
        v = b && fr_en && x >= fr_px && x < fr_px + SW * fr_s
                       && y >= fr_py && y < fr_py + SH * fr_s;
        h_hit[2] = h_hit[1]; h_idx[2] = h_idx[1];
        h_hit[1] = h_hit[0]; h_idx[1] = h_idx[0];
        h_hit[0] = 0; h_idx[0] = 0;
        if (v) begin
            col = (x - fr_px) / fr_s;
            row = (y - fr_py) / fr_s;
            a = row * SW + (fr_flip ? SW - 1 - col : col);
            e_addr = a;
            h_idx[0] = int'(rom_mem[a]);
            h_hit[0] = (rom_mem[a] != 8'd0);
        end
        @(posedge vga_clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(700, 500, 1'b0);
    endtask

    task automatic test_reset();
        model_reset();
        for (int a = 0; a < SW*SH; a++) rom_mem[a] = 8'd0;
        reset_n = 1'b0;
        repeat (2) @(posedge vga_clk);
        #1;
        vectors++;
        if (rif.rom_address !== 10'd0) begin miscompares++; $display("FAIL reset addr got %0d want 0", rif.rom_address); end
        vectors++;
        if (pix_hit !== 1'b0) begin miscompares++; $display("FAIL reset hit got %0b want 0", pix_hit); end
        vectors++;
        if (pix_index !== 8'd0) begin miscompares++; $display("FAIL reset index got %0d want 0", pix_index); end
        @(negedge vga_clk) reset_n = 1'b1;
    endtask

    task automatic test_basic();
        idle(3);
        for (int a = 0; a < SW*SH; a++) rom_mem[a] = (a % 2 == 1) ? 8'd5 : 8'd0;
        pos_x = 10'd100; pos_y = 10'd50; scale = 3'd1; flip_x = 0; enable = 1;
        step(0, 0, 1);
        for (int y = 50; y <= 52; y++)
            for (int k = 0; k <= 135 - 98 + 1; k++) begin
                int x;
                x = (k == 0) ? 0 : 98 + k - 1;
                step(x, y, 1);
                vectors++;
                if (rif.rom_address !== AW'(e_addr)) begin miscompares++; $display("FAIL basic addr (%0d,%0d) got %0d want %0d", x, y, rif.rom_address, e_addr); end
                vectors++;
                if (pix_hit !== h_hit[2] || (h_hit[2] && pix_index !== IW'(h_idx[2]))) begin miscompares++; $display("FAIL basic pix (%0d,%0d) got %0b/%0d want %0b/%0d", x, y, pix_hit, pix_index, h_hit[2], h_idx[2]); end
                if (y == 50 && x == 101) begin
                    vectors++;
                    if (rif.rom_address !== 10'd1) begin miscompares++; $display("FAIL basic addr101 got %0d want 1", rif.rom_address); end
                end
                if (y == 50 && x == 102) begin
                    vectors++;
                    if (pix_hit !== 1'b0) begin miscompares++; $display("FAIL basic hit100 got %0b want 0", pix_hit); end
                end
                if (y == 50 && x == 103) begin
                    vectors++;
                    if (pix_hit !== 1'b1 || pix_index !== 8'd5) begin miscompares++; $display("FAIL basic pix101 got %0b/%0d want 1/5", pix_hit, pix_index); end
                end
            end
    endtask

    task automatic test_scale();
        idle(3);
        for (int a = 0; a < SW*SH; a++) rom_mem[a] = IW'(a % 255 + 1);
        pos_x = 10'd0; pos_y = 10'd0; scale = 3'd3; flip_x = 0; enable = 1;
        for (int y = 0; y <= 4; y++)
            for (int k = 0; k <= 100; k++) begin
                int x;
                x = k;
                step(x, y, 1);
                vectors++;
                if (rif.rom_address !== AW'(e_addr)) begin miscompares++; $display("FAIL scale addr (%0d,%0d) got %0d want %0d", x, y, rif.rom_address, e_addr); end
                vectors++;
                if (pix_hit !== h_hit[2] || (h_hit[2] && pix_index !== IW'(h_idx[2]))) begin miscompares++; $display("FAIL scale pix (%0d,%0d) got %0b/%0d want %0b/%0d", x, y, pix_hit, pix_index, h_hit[2], h_idx[2]); end
                if (y == 0 && x <= 3) begin
                    vectors++;
                    if (rif.rom_address !== ((x == 3) ? 10'd1 : 10'd0)) begin miscompares++; $display("FAIL scale addr_x%0d got %0d", x, rif.rom_address); end
                end
                if (y == 3 && x == 0) begin
                    vectors++;
                    if (rif.rom_address !== 10'd32) begin miscompares++; $display("FAIL scale row1 got %0d want 32", rif.rom_address); end
                end
                if (y == 0 && (x == 97 || x == 98)) begin
                    vectors++;
                    if (pix_hit !== (x == 97)) begin miscompares++; $display("FAIL scale edge_x%0d hit got %0b", x - 2, pix_hit); end
                end
            end
    endtask

    task automatic test_flip();
        idle(3);
        for (int a = 0; a < SW*SH; a++) rom_mem[a] = IW'(a % 255 + 1);
        pos_x = 10'd10; pos_y = 10'd10; scale = 3'd1; flip_x = 1; enable = 1;
        step(0, 0, 1);
        for (int y = 10; y <= 11; y++)
            for (int k = 0; k <= 45 - 5 + 1; k++) begin
                int x;
                x = (k == 0) ? 0 : 5 + k - 1;
                step(x, y, 1);
                vectors++;
                if (rif.rom_address !== AW'(e_addr)) begin miscompares++; $display("FAIL flip addr (%0d,%0d) got %0d want %0d", x, y, rif.rom_address, e_addr); end
                vectors++;
                if (pix_hit !== h_hit[2] || (h_hit[2] && pix_index !== IW'(h_idx[2]))) begin miscompares++; $display("FAIL flip pix (%0d,%0d) got %0b/%0d want %0b/%0d", x, y, pix_hit, pix_index, h_hit[2], h_idx[2]); end
                if (y == 10 && (x == 10 || x == 41)) begin
                    vectors++;
                    if (rif.rom_address !== ((x == 10) ? 10'd31 : 10'd0)) begin miscompares++; $display("FAIL flip addr_x%0d got %0d", x, rif.rom_address); end
                end
            end
    endtask

    task automatic test_clip();
        idle(3);
        for (int a = 0; a < SW*SH; a++) rom_mem[a] = IW'(a % 255 + 1);
        pos_x = 10'd620; pos_y = 10'd470; scale = 3'd1; flip_x = 0; enable = 1;
        step(0, 0, 1);
        for (int y = 468; y <= V_ACTIVE; y++)
            for (int k = 0; k <= H_ACTIVE - 1 - 600 + 1; k++) begin
                int x;
                x = (k == 0) ? 0 : 600 + k - 1;
                step(x, y, y < V_ACTIVE);
                vectors++;
                if (rif.rom_address !== AW'(e_addr)) begin miscompares++; $display("FAIL clip addr (%0d,%0d) got %0d want %0d", x, y, rif.rom_address, e_addr); end
                vectors++;
                if (pix_hit !== h_hit[2] || (h_hit[2] && pix_index !== IW'(h_idx[2]))) begin miscompares++; $display("FAIL clip pix (%0d,%0d) got %0b/%0d want %0b/%0d", x, y, pix_hit, pix_index, h_hit[2], h_idx[2]); end
                if (y == V_ACTIVE - 1 && x == H_ACTIVE - 1) begin
                    vectors++;
                    if (rif.rom_address !== 10'd307) begin miscompares++; $display("FAIL clip last addr got %0d want 307", rif.rom_address); end
                end
            end
    endtask

    task automatic test_shadow();
        idle(3);
        for (int a = 0; a < SW*SH; a++) rom_mem[a] = ($urandom_range(0, 3) == 0) ? 8'd0 : IW'($urandom_range(1, 255));
        pos_x = 10'd100; pos_y = 10'd230; scale = 3'd1; flip_x = 0; enable = 1;
        for (int f = 0; f < 2; f++) begin
            step(0, 0, 1);
            for (int y = 230; y <= ((f == 0) ? 245 : 233); y++) begin
                if (y == 240) pos_x = 10'd200;
                for (int k = 0; k <= 235 - 95 + 1; k++) begin
                    int x;
                    x = (k == 0) ? 0 : 95 + k - 1;
                    step(x, y, 1);
                    vectors++;
                    if (rif.rom_address !== AW'(e_addr)) begin miscompares++; $display("FAIL shadow addr f%0d (%0d,%0d) got %0d want %0d", f, x, y, rif.rom_address, e_addr); end
                    vectors++;
                    if (pix_hit !== h_hit[2] || (h_hit[2] && pix_index !== IW'(h_idx[2]))) begin miscompares++; $display("FAIL shadow pix f%0d (%0d,%0d) got %0b/%0d want %0b/%0d", f, x, y, pix_hit, pix_index, h_hit[2], h_idx[2]); end
                    if ((f == 0 && y == 241 && x == 100) || (f == 1 && y == 230 && x == 231)) begin
                        vectors++;
                        if (rif.rom_address !== ((f == 0) ? 10'd352 : 10'd31)) begin miscompares++; $display("FAIL shadow place f%0d got %0d", f, rif.rom_address); end
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            int px, py, s, ya, yb, xa, xb;
            idle(3);
            for (int a = 0; a < SW*SH; a++) rom_mem[a] = ($urandom_range(0, 3) == 0) ? 8'd0 : IW'($urandom_range(1, 255));
            px = $urandom_range(0, H_ACTIVE - 1);
            py = $urandom_range(0, V_ACTIVE - 1);
            s  = $urandom_range(0, 3);
            pos_x = coord_t'(px); pos_y = coord_t'(py); scale = SCW'(s);
            flip_x = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 4) != 0);
            if (s == 0) s = 1;
            ya = (py >= 2) ? py - 2 : 0;
            yb = py + SH * s + 1;
            if (yb > V_ACTIVE - 1) yb = V_ACTIVE - 1;
            xa = (px > 4) ? px - int'($urandom_range(0, 4)) : 1;
            xb = px + SW * s + 2;
            if (xb > H_ACTIVE - 1) xb = H_ACTIVE - 1;
            if (ya > 0) step(0, 0, 1);
            for (int y = ya; y <= yb; y++)
                for (int k = 0; k <= xb - xa + 1; k++) begin
                    int x;
                    x = (k == 0) ? 0 : xa + k - 1;
                    step(x, y, $urandom_range(0, 9) != 0);
                    vectors++;
                    if (rif.rom_address !== AW'(e_addr)) begin miscompares++; $display("FAIL random addr f%0d (%0d,%0d) got %0d want %0d", f, x, y, rif.rom_address, e_addr); end
                    vectors++;
                    if (pix_hit !== h_hit[2] || (h_hit[2] && pix_index !== IW'(h_idx[2]))) begin miscompares++; $display("FAIL random pix f%0d (%0d,%0d) got %0b/%0d want %0b/%0d", f, x, y, pix_hit, pix_index, h_hit[2], h_idx[2]); end
                end
        end
    endtask

    task automatic test_reset_mid();
        idle(3);
        for (int a = 0; a < SW*SH; a++) rom_mem[a] = IW'(a % 255 + 1);
        pos_x = 10'd100; pos_y = 10'd50; scale = 3'd1; flip_x = 0; enable = 1;
        for (int ph = 0; ph < 3; ph++) begin
            if (ph != 1) step(0, 0, 1);
            for (int y = ((ph == 1) ? 52 : 50); y <= ((ph == 1) ? 55 : 52); y++)
                for (int k = 0; k <= 140 - 95 + 1; k++) begin
                    int x;
                    x = (k == 0) ? 0 : 95 + k - 1;
                    if (ph == 1 && y == 52 && x <= 110) continue;
                    step(x, y, 1);
                    vectors++;
                    if (rif.rom_address !== AW'(e_addr)) begin miscompares++; $display("FAIL rstmid addr p%0d (%0d,%0d) got %0d want %0d", ph, x, y, rif.rom_address, e_addr); end
                    vectors++;
                    if (pix_hit !== h_hit[2] || (h_hit[2] && pix_index !== IW'(h_idx[2]))) begin miscompares++; $display("FAIL rstmid pix p%0d (%0d,%0d) got %0b/%0d want %0b/%0d", ph, x, y, pix_hit, pix_index, h_hit[2], h_idx[2]); end
                    if (ph == 0 && y == 52 && x == 110) break;
                end
            if (ph == 0) begin
                #2 reset_n = 1'b0;
                #1;
                vectors++;
                if (rif.rom_address !== 10'd0) begin miscompares++; $display("FAIL rstmid async addr got %0d want 0", rif.rom_address); end
                vectors++;
                if (pix_hit !== 1'b0) begin miscompares++; $display("FAIL rstmid async hit got %0b want 0", pix_hit); end
                model_reset();
                @(negedge vga_clk) reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        for (int a = 0; a < SW*SH; a++) rom_mem[a] = 8'd0;
        test_reset();
        test_basic();
        test_scale();
        test_flip();
        test_clip();
        test_shadow();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
